// File: rtl/mult_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mult_pkg: shared width default, FSM states, Booth digit codes.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_t;

endpackage
`default_nettype wire

// File: rtl/booth_r4_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | booth_r4_encoder: maps a 3-bit multiplier window to a digit.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module booth_r4_encoder
  import mult_pkg::*;
(
  input  logic [2:0] win,
  output booth_t     enc
);

  always_comb begin
    enc = ZERO;
    case (win)
      3'b001, 3'b010: enc = POS1;
      3'b011:         enc = POS2;
      3'b100:         enc = NEG2;
      3'b101, 3'b110: enc = NEG1;
      default:        enc = ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_booth_multiplier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_booth_multiplier: radix-4 Booth multiplier, one digit/cycle. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int XW    = WIDTH + 2;
  localparam int STEPS = WIDTH / 2 + 1;
  localparam int CW    = $clog2(STEPS + 1);

  state_t                 state_q, state_d;
  logic [XW-1:0]          a_q, a_d;
  logic [XW-1:0]          acc_q, acc_d;
  logic [XW:0]            mq_q, mq_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     p_q, p_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  booth_t                 digit;
  logic [XW-1:0]          addend;
  logic                   sub;
  logic [XW-1:0]          sum;
  logic [XW-1:0]          step_acc;
  logic [XW:0]            step_mq;
  logic [XW-1:0]          a_ext;
  logic [XW-1:0]          b_ext;

  // mq_q holds the not-yet-retired multiplier bits with the b[-1] guard in bit 0.
  booth_r4_encoder u_enc (
    .win (mq_q[2:0]),
    .enc (digit)
  );

  always_comb begin
    addend = '0;
    sub    = 1'b0;
    case (digit)
      POS1: addend = a_q;
      POS2: addend = {a_q[XW-2:0], 1'b0};
      NEG1: begin addend = ~a_q;                 sub = 1'b1; end
      NEG2: begin addend = ~{a_q[XW-2:0], 1'b0}; sub = 1'b1; end
      default: addend = '0;
    endcase
  end

  assign sum      = acc_q + addend + {{(XW-1){1'b0}}, sub};
  assign step_acc = {{2{sum[XW-1]}}, sum[XW-1:2]};
  assign step_mq  = {sum[1:0], mq_q[XW:2]};

  assign a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    acc_d       = acc_q;
    mq_d        = mq_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a_ext;
          mq_d       = {b_ext, 1'b0};
          acc_d      = '0;
          cnt_d      = CW'(STEPS);
          state_d    = CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      CALC: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // All multiplier bits are shifted out: {acc, mq[XW:1]} is the full product.
          p_d         = {step_acc[WIDTH-3:0], step_mq[XW:1]};
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_booth_multiplier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seq_booth_multiplier: directed vectors for the Booth multiplier|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_seq_booth_multiplier;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic            signed_mode = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*W-1:0]  p;
  logic            busy;

  int errors = 0;
  int checks = 0;

  seq_booth_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one operation, scramble inputs during CALC, check latency and product.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic m);
    @(negedge clk);
    a = ta; b = tb_; signed_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEADBEEF; b = 32'h13579BDF; signed_mode = ~m;
  endtask

  task automatic wait_result(input string tag, input logic [63:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin
        in_valid = 1'b1;
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      end
      if (lat == 6) in_valid = 1'b0;
    end
    check({tag, "_lat"}, 64'(lat), 64'd17);
    check({tag, "_p"}, p, exp);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic m, input logic [63:0] exp);
    start_op(ta, tb_, m);
    wait_result(tag, exp);
    consume(tag);
  endtask

  initial begin
    logic [63:0] held;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_p", p, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sgn_neg_neg", 32'hFFFFFFD5, 32'hFFFFFFD0, 1'b1, 64'd2064);
    run_op("mix_23", 32'd23, 32'hFFFFFFF1, 1'b1, 64'hFFFFFFFFFFFFFEA7);
    run_op("mix_125", 32'd125, 32'hFFFFFFEE, 1'b1, 64'hFFFFFFFFFFFFF736);
    run_op("uns_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
    run_op("sgn_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1);
    run_op("sgn_min_min", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
    run_op("uns_min_min", 32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000);
    run_op("sgn_min_max", 32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000);
    run_op("uns_ff_x2", 32'hFFFFFFFF, 32'd2, 1'b0, 64'h00000001FFFFFFFE);
    run_op("uns_dec", 32'd12345, 32'd6789, 1'b0, 64'd83810205);
    run_op("zero", 32'd10, 32'd0, 1'b0, 64'd0);
    run_op("one", 32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF80000000);

    // Backpressure: result must hold while out_ready is low; in_valid is ignored.
    start_op(32'd7, 32'd9, 1'b0);
    wait_result("bp", 64'd63);
    held = p;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
      check("bp_p_hold", p, held);
      check("bp_ov_ir", {62'd0, out_valid, in_ready}, 64'd2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume("bp");
    check("bp_p_after", p, 64'd63);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_start", {63'd0, busy}, 64'd0);

    // Reset during CALC at iteration 8: no output pulse, clean restart.
    start_op(32'd1000, 32'd1000, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ir", {63'd0, in_ready}, 64'd1);
    check("rst_mid_p", p, 64'd0);
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("rst_mid_ov", 64'(n), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 32'd50, 32'd50, 1'b0, 64'd2500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
